// File: rtl/dac_bus_pkg.sv
// Shared types and constants for the DAC bus responder: channel/data widths,
// the transaction state encoding, the packed bus bundle and its reset value.
package dac_bus_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECTED = 2'd1,
    WRITING  = 2'd2
  } state_t;

  // Every bus pin travels through the synchronizer as one field of this bundle.
  typedef struct packed {
    logic              cs_n;
    logic              wr_n;
    logic              ldac_n;
    logic              clr_n;
    logic              pd;
    logic              gain;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_t;

  localparam int unsigned BUS_W = $bits(bus_t);

  // Active-low strobes idle high, so the synchronizer must not show a
  // spurious falling edge as it leaves reset.
  localparam logic CS_RST   = 1'b1;
  localparam logic WR_RST   = 1'b1;
  localparam logic LDAC_RST = 1'b1;
  localparam logic CLR_RST  = 1'b1;

  localparam bus_t BUS_RST = '{
    cs_n:   CS_RST,
    wr_n:   WR_RST,
    ldac_n: LDAC_RST,
    clr_n:  CLR_RST,
    pd:     1'b0,
    gain:   1'b0,
    addr:   '0,
    data:   '0
  };

  typedef logic [NUM_CH-1:0][DATA_W-1:0] regs_t;

  // Returns the register bank with one channel replaced when en is set.
  function automatic regs_t write_through(input regs_t             regs,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] data,
                                          input logic              en);
    regs_t result;
    result = regs;
    if (en) result[addr] = data;
    return result;
  endfunction

endpackage

// File: rtl/bus_sync.sv
// Multi-stage flip-flop synchronizer for a bundle of asynchronous inputs.
// Each bit gets its own identical chain; RST_VAL sets the per-bit reset level.
module bus_sync #(
  parameter int unsigned     WIDTH       = 1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_VAL    = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // A single stage gives no metastability protection at all.
  if (SYNC_STAGES < 2) begin : g_stage_check
    $error("bus_sync needs at least 2 stages");
  end

  // Element 0 is the first (pin-facing) stage.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_d;

  // Shift the pin values one stage deeper every cycle.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
  end

  // Chain registers, preset to the idle bus levels.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{RST_VAL}};
    else       sync_q <= sync_d;
  end

  assign dout = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/dac_bus_receiver.sv
// Responder for the quad 8-bit parallel DAC bus. Synchronizes the bus,
// tracks CS/WR transactions, commits writes into per-channel input registers,
// transfers them to the output registers on LDAC falling, and flags protocol
// violations in a sticky error bit.
module dac_bus_receiver
  import dac_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CS,
  input  logic              WR,
  input  logic              LDAC,
  input  logic              CLR,
  input  logic              PD,
  input  logic              GAIN,
  input  logic              A0,
  input  logic              A1,
  input  logic [DATA_W-1:0] DATA,
  input  logic              err_clear,
  output logic [DATA_W-1:0] dac0,
  output logic [DATA_W-1:0] dac1,
  output logic [DATA_W-1:0] dac2,
  output logic [DATA_W-1:0] dac3,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              update_strobe,
  output logic              powered,
  output logic              gain,
  output logic              proto_err
);

  // ---------------------------------------------------------------------------
  // Synchronizer
  // ---------------------------------------------------------------------------
  bus_t             bus_raw;
  bus_t             bus_s;
  logic [BUS_W-1:0] bus_sync_out;

  assign bus_raw = '{
    cs_n:   CS,
    wr_n:   WR,
    ldac_n: LDAC,
    clr_n:  CLR,
    pd:     PD,
    gain:   GAIN,
    addr:   {A1, A0},
    data:   DATA
  };

  bus_sync #(
    .WIDTH       (BUS_W),
    .SYNC_STAGES (SYNC_STAGES),
    .RST_VAL     (BUS_RST)
  ) u_bus_sync (
    .clk   (clk),
    .reset (reset),
    .din   (bus_raw),
    .dout  (bus_sync_out)
  );

  assign bus_s = bus_t'(bus_sync_out);

  // ---------------------------------------------------------------------------
  // Edge detection on the last synchronizer stage
  // ---------------------------------------------------------------------------
  logic wr_prev_q, wr_prev_d;
  logic ldac_prev_q, ldac_prev_d;
  logic wr_rise, wr_fall, ldac_fall;

  // Delayed copies of the synchronized strobes.
  always_comb begin
    wr_prev_d   = bus_s.wr_n;
    ldac_prev_d = bus_s.ldac_n;
  end

  // Edge-history flops, idle high like the strobes themselves.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_prev_q   <= WR_RST;
      ldac_prev_q <= LDAC_RST;
    end else begin
      wr_prev_q   <= wr_prev_d;
      ldac_prev_q <= ldac_prev_d;
    end
  end

  assign wr_rise   = ~wr_prev_q &  bus_s.wr_n;
  assign wr_fall   =  wr_prev_q & ~bus_s.wr_n;
  assign ldac_fall =  ldac_prev_q & ~bus_s.ldac_n;

  // ---------------------------------------------------------------------------
  // Transaction state machine
  // ---------------------------------------------------------------------------
  state_t state_q, state_d;
  logic   fsm_commit;
  logic   fsm_abort;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state from the synchronized CS/WR levels.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!bus_s.cs_n) state_d = bus_s.wr_n ? SELECTED : WRITING;
      end
      SELECTED: begin
        if (bus_s.cs_n)       state_d = IDLE;
        else if (!bus_s.wr_n) state_d = WRITING;
      end
      WRITING: begin
        if (bus_s.cs_n)      state_d = IDLE;
        else if (bus_s.wr_n) state_d = SELECTED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Commit on WR rising while still selected; CS leaving mid-write aborts.
  // CS and WR rising together also counts as an abort: the write was never
  // closed by WR while the device was selected.
  always_comb begin
    fsm_commit = 1'b0;
    fsm_abort  = 1'b0;
    if (state_q == WRITING) begin
      fsm_commit = ~bus_s.cs_n & wr_rise;
      fsm_abort  =  bus_s.cs_n;
    end
  end

  // ---------------------------------------------------------------------------
  // Register banks, write report, strobes and error flag
  // ---------------------------------------------------------------------------
  regs_t             in_reg_q, in_reg_d;
  regs_t             dac_q, dac_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_strobe_q, wr_strobe_d;
  logic              update_strobe_q, update_strobe_d;
  logic              proto_err_q, proto_err_d;

  logic clr_active;
  logic commit;
  logic update;
  logic violation;

  assign clr_active = ~bus_s.clr_n;
  assign commit     = fsm_commit & ~clr_active;
  assign update     = ldac_fall & ~clr_active;
  assign violation  = fsm_abort | (wr_fall & bus_s.cs_n);

  // Bank updates: a commit lands in the input bank, and an LDAC edge in the
  // same cycle copies the already-updated bank so the new value passes
  // straight through. CLR overrides everything.
  always_comb begin
    in_reg_d = write_through(in_reg_q, bus_s.addr, bus_s.data, commit);
    dac_d    = update ? in_reg_d : dac_q;
    if (clr_active) begin
      in_reg_d = '0;
      dac_d    = '0;
    end
  end

  // Write report, one-cycle strobes and the sticky error flag.
  always_comb begin
    wr_addr_d       = commit ? bus_s.addr : wr_addr_q;
    wr_data_d       = commit ? bus_s.data : wr_data_q;
    wr_strobe_d     = commit;
    update_strobe_d = update;
    // A fresh violation wins over a simultaneous clear.
    proto_err_d     = violation | (proto_err_q & ~err_clear);
  end

  // Datapath registers.
  // NOTE: the channel banks are only eight bytes and must read back as zero
  // after reset, so they are reset like ordinary control flops rather than
  // being left to power-up contents like a RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_reg_q        <= '0;
      dac_q           <= '0;
      wr_addr_q       <= '0;
      wr_data_q       <= '0;
      wr_strobe_q     <= 1'b0;
      update_strobe_q <= 1'b0;
      proto_err_q     <= 1'b0;
    end else begin
      in_reg_q        <= in_reg_d;
      dac_q           <= dac_d;
      wr_addr_q       <= wr_addr_d;
      wr_data_q       <= wr_data_d;
      wr_strobe_q     <= wr_strobe_d;
      update_strobe_q <= update_strobe_d;
      proto_err_q     <= proto_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign dac0          = dac_q[0];
  assign dac1          = dac_q[1];
  assign dac2          = dac_q[2];
  assign dac3          = dac_q[3];
  assign wr_strobe     = wr_strobe_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = wr_data_q;
  assign update_strobe = update_strobe_q;
  assign proto_err     = proto_err_q;
  assign powered       = bus_s.pd;
  assign gain          = bus_s.gain;

endmodule

// File: tb/tb_dac_bus_receiver.sv
// Directed testbench for dac_bus_receiver (SYNC_STAGES = 2, 3-cycle
// pin-to-strobe latency). Inputs are driven and outputs sampled 1 ns after
// each rising clock edge.
module tb_dac_bus_receiver;

  logic       clk = 1'b0;
  logic       reset;
  logic       CS, WR, LDAC, CLR, PD, GAIN, A0, A1;
  logic [7:0] DATA;
  logic       err_clear;
  logic [7:0] dac0, dac1, dac2, dac3;
  logic       wr_strobe;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;
  logic       update_strobe;
  logic       powered;
  logic       gain;
  logic       proto_err;

  int n_cmp = 0;
  int n_mis = 0;
  int wr_cnt = 0;
  int upd_cnt = 0;

  dac_bus_receiver #(.SYNC_STAGES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .CS            (CS),
    .WR            (WR),
    .LDAC          (LDAC),
    .CLR           (CLR),
    .PD            (PD),
    .GAIN          (GAIN),
    .A0            (A0),
    .A1            (A1),
    .DATA          (DATA),
    .err_clear     (err_clear),
    .dac0          (dac0),
    .dac1          (dac1),
    .dac2          (dac2),
    .dac3          (dac3),
    .wr_strobe     (wr_strobe),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .update_strobe (update_strobe),
    .powered       (powered),
    .gain          (gain),
    .proto_err     (proto_err)
  );

  always #5 clk = ~clk;

  // Strobe pulse counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr_strobe === 1'b1)     wr_cnt++;
    if (update_strobe === 1'b1) upd_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input logic [1:0] a);
    A1 = a[1];
    A0 = a[0];
  endtask

  // Complete bus write with generous hold after WR rising.
  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    set_addr(a);
    DATA = d;
    CS   = 1'b0;
    tick(2);
    WR = 1'b0;
    tick(3);
    WR = 1'b1;
    tick(4);
    CS = 1'b1;
    tick(3);
  endtask

  task automatic ldac_pulse();
    LDAC = 1'b0;
    tick(4);
    LDAC = 1'b1;
    tick(4);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    CS = 1'b1; WR = 1'b1; LDAC = 1'b1; CLR = 1'b1;
    PD = 1'b0; GAIN = 1'b0; A0 = 1'b0; A1 = 1'b0;
    DATA = 8'h00; err_clear = 1'b0;
    tick(3);
    n_cmp++;
    if ({dac3, dac2, dac1, dac0} !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_dacs: got %h want %h", {dac3, dac2, dac1, dac0}, 32'h0);
    end
    n_cmp++;
    if ({wr_strobe, update_strobe, proto_err, powered, gain} !== 5'b0) begin
      n_mis++;
      $display("FAIL reset_flags: got %b want %b",
               {wr_strobe, update_strobe, proto_err, powered, gain}, 5'b0);
    end
    n_cmp++;
    if ({wr_addr, wr_data} !== 10'h0) begin
      n_mis++;
      $display("FAIL reset_wr_report: got %h want %h", {wr_addr, wr_data}, 10'h0);
    end
    reset = 1'b0;
    tick(4);
    n_cmp++;
    if ({proto_err, wr_cnt, upd_cnt} !== {1'b0, 32'd0, 32'd0}) begin
      n_mis++;
      $display("FAIL post_reset_quiet: got err=%b wr=%0d upd=%0d want 0 0 0",
               proto_err, wr_cnt, upd_cnt);
    end
  endtask

  task automatic test_pd_gain();
    PD = 1'b1;
    GAIN = 1'b1;
    tick(1);
    n_cmp++;
    if ({powered, gain} !== 2'b00) begin
      n_mis++;
      $display("FAIL pd_gain_early: got %b want %b", {powered, gain}, 2'b00);
    end
    tick(1);
    n_cmp++;
    if ({powered, gain} !== 2'b11) begin
      n_mis++;
      $display("FAIL pd_gain_sync: got %b want %b", {powered, gain}, 2'b11);
    end
  endtask

  task automatic test_single_write();
    int w0, u0;
    w0 = wr_cnt;
    u0 = upd_cnt;
    set_addr(2'd2);
    DATA = 8'hA5;
    CS = 1'b0;
    WR = 1'b0;
    tick(4);
    WR = 1'b1;
    tick(2);
    n_cmp++;
    if (wr_strobe !== 1'b0) begin
      n_mis++;
      $display("FAIL single_strobe_early: got %b want 0", wr_strobe);
    end
    tick(1);
    n_cmp++;
    if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 2'd2, 8'hA5}) begin
      n_mis++;
      $display("FAIL single_commit: got strobe=%b addr=%0d data=%h want 1 2 a5",
               wr_strobe, wr_addr, wr_data);
    end
    tick(1);
    n_cmp++;
    if (wr_strobe !== 1'b0) begin
      n_mis++;
      $display("FAIL single_strobe_width: got %b want 0", wr_strobe);
    end
    CS = 1'b1;
    tick(4);
    LDAC = 1'b0;
    tick(2);
    n_cmp++;
    if (dac2 !== 8'h00) begin
      n_mis++;
      $display("FAIL single_dac2_early: got %h want 00", dac2);
    end
    tick(1);
    n_cmp++;
    if ({update_strobe, dac3, dac2, dac1, dac0} !== {1'b1, 32'h00A50000}) begin
      n_mis++;
      $display("FAIL single_update: got upd=%b dacs=%h want 1 00a50000",
               update_strobe, {dac3, dac2, dac1, dac0});
    end
    LDAC = 1'b1;
    tick(4);
    n_cmp++;
    if ({wr_cnt - w0, upd_cnt - u0} !== {32'd1, 32'd1}) begin
      n_mis++;
      $display("FAIL single_counts: got wr=%0d upd=%0d want 1 1", wr_cnt - w0, upd_cnt - u0);
    end
  endtask

  task automatic test_burst();
    int w0;
    w0 = wr_cnt;
    bus_write(2'd0, 8'h11);
    bus_write(2'd1, 8'h22);
    bus_write(2'd2, 8'h33);
    bus_write(2'd3, 8'h44);
    n_cmp++;
    if (wr_cnt - w0 !== 4) begin
      n_mis++;
      $display("FAIL burst_wr_count: got %0d want 4", wr_cnt - w0);
    end
    n_cmp++;
    if ({dac3, dac2, dac1, dac0} !== 32'h00A50000) begin
      n_mis++;
      $display("FAIL burst_dacs_held: got %h want 00a50000", {dac3, dac2, dac1, dac0});
    end
    LDAC = 1'b0;
    tick(2);
    n_cmp++;
    if ({update_strobe, dac0} !== {1'b0, 8'h00}) begin
      n_mis++;
      $display("FAIL burst_early: got upd=%b dac0=%h want 0 00", update_strobe, dac0);
    end
    tick(1);
    n_cmp++;
    if ({update_strobe, dac3, dac2, dac1, dac0} !== {1'b1, 32'h44332211}) begin
      n_mis++;
      $display("FAIL burst_update: got upd=%b dacs=%h want 1 44332211",
               update_strobe, {dac3, dac2, dac1, dac0});
    end
    LDAC = 1'b1;
    tick(4);
  endtask

  task automatic test_protocol_error();
    int w0;
    w0 = wr_cnt;
    // CS leaves while WR is still low.
    set_addr(2'd1);
    DATA = 8'h99;
    CS = 1'b0;
    WR = 1'b0;
    tick(4);
    CS = 1'b1;
    tick(2);
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_mis++;
      $display("FAIL abort_err_early: got %b want 0", proto_err);
    end
    tick(1);
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_mis++;
      $display("FAIL abort_err: got %b want 1", proto_err);
    end
    WR = 1'b1;
    tick(4);
    n_cmp++;
    if (wr_cnt - w0 !== 0) begin
      n_mis++;
      $display("FAIL abort_no_commit: got %0d strobes want 0", wr_cnt - w0);
    end
    ldac_pulse();
    n_cmp++;
    if (dac1 !== 8'h22) begin
      n_mis++;
      $display("FAIL abort_inreg_kept: got dac1=%h want 22", dac1);
    end
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_mis++;
      $display("FAIL err_sticky: got %b want 1", proto_err);
    end
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    n_cmp++;
    if (proto_err !== 1'b0) begin
      n_mis++;
      $display("FAIL err_clear: got %b want 0", proto_err);
    end
    // WR toggling while deselected.
    WR = 1'b0;
    tick(3);
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_mis++;
      $display("FAIL wr_while_deselected: got %b want 1", proto_err);
    end
    WR = 1'b1;
    tick(3);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    tick(1);
    // Clear and new violation on the same edge: violation wins.
    WR = 1'b0;
    tick(2);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    n_cmp++;
    if (proto_err !== 1'b1) begin
      n_mis++;
      $display("FAIL clear_vs_violation: got %b want 1", proto_err);
    end
    WR = 1'b1;
    tick(3);
    err_clear = 1'b1;
    tick(1);
    err_clear = 1'b0;
    n_cmp++;
    if ({proto_err, wr_cnt - w0} !== {1'b0, 32'd0}) begin
      n_mis++;
      $display("FAIL proto_end: got err=%b strobes=%0d want 0 0", proto_err, wr_cnt - w0);
    end
  endtask

  task automatic test_clr();
    int w0, u0;
    bus_write(2'd1, 8'h7F);
    ldac_pulse();
    n_cmp++;
    if (dac1 !== 8'h7F) begin
      n_mis++;
      $display("FAIL clr_preload: got dac1=%h want 7f", dac1);
    end
    CLR = 1'b0;
    tick(2);
    n_cmp++;
    if (dac1 !== 8'h7F) begin
      n_mis++;
      $display("FAIL clr_early: got dac1=%h want 7f", dac1);
    end
    tick(1);
    n_cmp++;
    if ({dac3, dac2, dac1, dac0} !== 32'h0) begin
      n_mis++;
      $display("FAIL clr_zero: got %h want 00000000", {dac3, dac2, dac1, dac0});
    end
    w0 = wr_cnt;
    u0 = upd_cnt;
    bus_write(2'd1, 8'h55);
    ldac_pulse();
    n_cmp++;
    if ({wr_cnt - w0, upd_cnt - u0, {24'h0, dac1}} !== {32'd0, 32'd0, 32'd0}) begin
      n_mis++;
      $display("FAIL clr_suppress: got wr=%0d upd=%0d dac1=%h want 0 0 00",
               wr_cnt - w0, upd_cnt - u0, dac1);
    end
    CLR = 1'b1;
    tick(4);
    ldac_pulse();
    n_cmp++;
    if ({upd_cnt - u0, {24'h0, dac1}} !== {32'd1, 32'd0}) begin
      n_mis++;
      $display("FAIL clr_after_release: got upd=%0d dac1=%h want 1 00", upd_cnt - u0, dac1);
    end
  endtask

  task automatic test_simultaneous();
    set_addr(2'd3);
    DATA = 8'hC3;
    CS = 1'b0;
    WR = 1'b0;
    tick(4);
    WR = 1'b1;
    LDAC = 1'b0;
    tick(2);
    n_cmp++;
    if ({wr_strobe, update_strobe, dac3} !== {2'b00, 8'h00}) begin
      n_mis++;
      $display("FAIL simul_early: got wr=%b upd=%b dac3=%h want 0 0 00",
               wr_strobe, update_strobe, dac3);
    end
    tick(1);
    n_cmp++;
    if ({wr_strobe, update_strobe, wr_addr, dac3} !== {2'b11, 2'd3, 8'hC3}) begin
      n_mis++;
      $display("FAIL simul_transparent: got wr=%b upd=%b addr=%0d dac3=%h want 1 1 3 c3",
               wr_strobe, update_strobe, wr_addr, dac3);
    end
    LDAC = 1'b1;
    CS = 1'b1;
    tick(4);
  endtask

  task automatic test_reset_mid_write();
    int w0;
    bus_write(2'd0, 8'h10);
    ldac_pulse();
    n_cmp++;
    if (dac0 !== 8'h10) begin
      n_mis++;
      $display("FAIL rst_preload: got dac0=%h want 10", dac0);
    end
    set_addr(2'd0);
    DATA = 8'h01;
    CS = 1'b0;
    WR = 1'b0;
    tick(4);
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({dac3, dac2, dac1, dac0, wr_addr, wr_data, proto_err, powered, gain} !== 45'h0) begin
      n_mis++;
      $display("FAIL rst_async: got dacs=%h addr=%0d data=%h err=%b pwr=%b gain=%b want all 0",
               {dac3, dac2, dac1, dac0}, wr_addr, wr_data, proto_err, powered, gain);
    end
    tick(2);
    reset = 1'b0;
    w0 = wr_cnt;
    tick(4);
    n_cmp++;
    if ({wr_cnt - w0, {31'h0, proto_err}} !== {32'd0, 32'd0}) begin
      n_mis++;
      $display("FAIL rst_resume_quiet: got wr=%0d err=%b want 0 0", wr_cnt - w0, proto_err);
    end
    WR = 1'b1;
    tick(3);
    n_cmp++;
    if ({wr_strobe, wr_addr, wr_data} !== {1'b1, 2'd0, 8'h01}) begin
      n_mis++;
      $display("FAIL rst_resume_commit: got strobe=%b addr=%0d data=%h want 1 0 01",
               wr_strobe, wr_addr, wr_data);
    end
    tick(2);
    CS = 1'b1;
    tick(4);
    ldac_pulse();
    n_cmp++;
    if ({dac3, dac2, dac1, dac0} !== 32'h00000001) begin
      n_mis++;
      $display("FAIL rst_resume_dac: got %h want 00000001", {dac3, dac2, dac1, dac0});
    end
  endtask

  initial begin
    test_reset();
    test_pd_gain();
    test_single_write();
    test_burst();
    test_protocol_error();
    test_clr();
    test_simultaneous();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
